input_event_unit: RTL
=====================

Name: input_event_unit

Overview:
Conditions raw board inputs into the special-register inputs of the CPU register file. Push buttons are synchronised, debounced and classified as short or long presses. A short press produces a one-cycle flag pulse on `flag_inputs`. A long press asserts `long_press`. Slide switches are synchronised into `reg_din`. Sits between the top-level pins and the register file.

Parameters:
- NUM_BTN, 7, number of buttons; drives `flag_inputs[NUM_BTN-1:0]`, max 7.
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a button level change (≥2).
- LONG_PRESS_CYCLES, 50000000, debounced hold cycles that classify a press as long (≥2).
- CNT_W, 26, width of the debounce and hold counters; must hold LONG_PRESS_CYCLES-1.

Ports:
- clk, input, 1, system clock.
- resetn, input, 1, reset, asynchronous, active-low.
- btn_raw, input, NUM_BTN, raw buttons, active-high pressed, asynchronous.
- sw_raw, input, 8, raw slide switches, asynchronous.
- flag_inputs, output, 8, one-cycle short-press pulses; bit i = button i; bits ≥ NUM_BTN tied 0.
- long_press, output, 1, high while any button is in the LONG state.
- reg_din, output, 8, synchronised switch value.
- btn_level, output, NUM_BTN, debounced button levels.

Behaviour:
- Reset (async, resetn=0):
  - All synchroniser flops, debounced levels, counters and outputs go to 0.
  - All per-button FSMs go to IDLE.
  - Effective immediately, including mid-press or mid-count.
- Synchronisers: two-flop synchroniser on every btn_raw and sw_raw bit.
  - reg_din equals the sw_raw value sampled 2 edges earlier; no debounce on switches.
- Debounce, per button:
  - Compare sync bit s with debounced level d.
  - If s==d: counter reset to 0.
  - If s!=d: counter increments each edge. On the edge where counter==DEBOUNCE_CYCLES-1 and s!=d still holds: d<=s and counter<=0.
  - Any single cycle with s==d restarts the count.
  - Net result: d changes DEBOUNCE_CYCLES+2 edges after a clean raw change.
  - btn_level = d.
- Press FSM, per button, registered; states IDLE, HELD, LONG:
  - IDLE: d=1 → HELD, hold counter <= 0.
  - HELD:
    - d=0 → IDLE, and flag_inputs[i] <= 1 for exactly one cycle.
    - Else if hold counter==LONG_PRESS_CYCLES-1 → LONG.
    - Else hold counter increments.
    - If release and threshold coincide, release wins: pulse emitted, no LONG entry.
  - LONG: d=0 → IDLE with no flag pulse. Hold counter frozen.
- Flag pulses:
  - flag_inputs is registered and cleared every cycle unless set as above.
  - Multiple buttons releasing on the same edge set their bits simultaneously.
  - A pulse never lasts more than 1 cycle.
- long_press: registered OR over all buttons of (state==LONG).
  - Rises 1 edge after the first FSM enters LONG.
  - Falls 1 edge after the last LONG button returns to IDLE.
- Latency, clean edges: raw release → flag pulse high during the cycle after edge DEBOUNCE_CYCLES+3.
- Reset released with a button held: treated as a fresh press. Full debounce, then HELD from hold count 0; no pulse or long_press carried across reset.
- No enable input: the block runs every cycle regardless of CPU state.

Test Plan:
All tests use DEBOUNCE_CYCLES=4 and LONG_PRESS_CYCLES=16.

1. Short press: btn_raw[2]=1 for 12 cycles, then 0 →
   - btn_level[2] rises 6 edges after press.
   - flag_inputs=8'h04 for exactly 1 cycle, 7 edges after release.
   - long_press stays 0.
2. Bounce: btn_raw[1] toggles 1,1,0,1,1,0 (period 3 cycles), then 0 → btn_level and flag_inputs stay 0 throughout.
3. Long press: btn_raw[0]=1 for 40 cycles →
   - long_press rises 24 edges after the raw rise.
   - On release, long_press falls 8 edges after the raw fall.
   - flag_inputs stays 8'h00.
4. Simultaneous releases: btn_raw[0] and btn_raw[5] pressed 10 cycles, released on the same edge → flag_inputs=8'h21 for one cycle; bit 7 stays 0 throughout.
5. Switches: sw_raw=8'hA5 → reg_din=8'hA5 2 edges later; then 8'h3C → 8'h3C 2 edges later.
6. Reset mid-long-press: assert resetn=0 while long_press=1 →
   - All outputs 0 asynchronously, before the next edge.
   - Release reset with the button still held: long_press re-asserts only after 24 further edges; no flag pulse on the eventual release.

Source files
------------

// File: rtl/input_event_unit_if.sv
// -----------------------------------------------------------------------------
// input_event_unit_if
//   Bundle between the board pins / register file and input_event_unit.
//
//   btn_raw     : raw push buttons, active-high pressed, asynchronous
//   sw_raw      : raw slide switches, asynchronous
//   flag_inputs : one-cycle short-press pulses, bit i = button i
//   long_press  : high while any button is held past the long-press threshold
//   reg_din     : synchronised switch value
//   btn_level   : debounced button levels
//
//   master : the pin side (drives raw inputs, consumes conditioned outputs)
//   slave  : the input_event_unit itself
// -----------------------------------------------------------------------------
interface input_event_unit_if #(
    parameter int NUM_BTN = 7
);
    logic [NUM_BTN-1:0] btn_raw;
    logic [7:0]         sw_raw;
    logic [7:0]         flag_inputs;
    logic               long_press;
    logic [7:0]         reg_din;
    logic [NUM_BTN-1:0] btn_level;

    modport master (
        output btn_raw, sw_raw,
        input  flag_inputs, long_press, reg_din, btn_level
    );

    modport slave (
        input  btn_raw, sw_raw,
        output flag_inputs, long_press, reg_din, btn_level
    );
endinterface

// File: rtl/input_event_unit.sv
// -----------------------------------------------------------------------------
// input_event_unit
//   Conditions raw board inputs for the special-register inputs of the CPU
//   register file. Buttons are synchronised, debounced and classified as
//   short presses (one-cycle pulse on flag_inputs) or long presses
//   (long_press level). Switches are synchronised straight into reg_din.
//
//   Ports:
//     clk    : system clock
//     resetn : asynchronous, active-low reset
//     bus    : input_event_unit_if.slave (btn_raw, sw_raw in;
//              flag_inputs, long_press, reg_din, btn_level out)
//
//   Parameters:
//     NUM_BTN           : number of buttons (max 7)
//     DEBOUNCE_CYCLES   : stable cycles needed to accept a level change (>=2)
//     LONG_PRESS_CYCLES : debounced hold cycles that make a press long (>=2)
//     CNT_W             : counter width, must hold LONG_PRESS_CYCLES-1
// -----------------------------------------------------------------------------
module input_event_unit #(
    parameter int NUM_BTN           = 7,
    parameter int DEBOUNCE_CYCLES   = 50000,
    parameter int LONG_PRESS_CYCLES = 50000000,
    parameter int CNT_W             = 26
) (
    input logic              clk,
    input logic              resetn,
    input_event_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        LONG = 2'd2
    } press_state_e;

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);

    // Synchroniser stages
    logic [NUM_BTN-1:0] btn_meta;
    logic [NUM_BTN-1:0] btn_sync;
    logic [7:0]         sw_meta;
    logic [7:0]         sw_sync;

    // Debounce state
    logic [NUM_BTN-1:0] level;
    logic [CNT_W-1:0]   db_cnt   [NUM_BTN];

    // Press classification state
    press_state_e       state    [NUM_BTN];
    logic [CNT_W-1:0]   hold_cnt [NUM_BTN];
    logic [NUM_BTN-1:0] flag_q;
    logic               long_q;
    logic               any_long;

    // -------------------------------------------------------------------------
    // Two-flop synchronisers on every asynchronous input bit.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its source, which is what makes the
    // two stages a real two-flop chain instead of collapsing into one.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            btn_meta <= '0;
            btn_sync <= '0;
            sw_meta  <= '0;
            sw_sync  <= '0;
        end else begin
            btn_meta <= bus.btn_raw;
            btn_sync <= btn_meta;
            sw_meta  <= bus.sw_raw;
            sw_sync  <= sw_meta;
        end
    end

    // -------------------------------------------------------------------------
    // Debounce: the synchronised bit must disagree with the accepted level for
    // DEBOUNCE_CYCLES consecutive edges before the level follows it. Any
    // agreeing cycle restarts the count.
    // -------------------------------------------------------------------------
    // NOTE: the per-button counter arrays are reset explicitly because a
    // half-finished count must not survive reset; these are small register
    // arrays, not RAM, so resetting them costs nothing structurally.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            level <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                if (btn_sync[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    level[i]  <= btn_sync[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Any button currently classified as long.
    // -------------------------------------------------------------------------
    // NOTE: any_long gets its default before the loop so every path assigns
    // it and no latch is inferred.
    always_comb begin
        any_long = 1'b0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (state[i] == LONG) begin
                any_long = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Per-button press FSM with registered flag and long_press outputs.
    // A release in HELD wins over reaching the long threshold on the same
    // edge, so a press is never both short and long.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            flag_q <= '0;
            long_q <= 1'b0;
            for (int i = 0; i < NUM_BTN; i++) begin
                state[i]    <= IDLE;
                hold_cnt[i] <= '0;
            end
        end else begin
            flag_q <= '0;
            long_q <= any_long;
            for (int i = 0; i < NUM_BTN; i++) begin
                unique case (state[i])
                    IDLE: begin
                        if (level[i]) begin
                            state[i]    <= HELD;
                            hold_cnt[i] <= '0;
                        end
                    end
                    HELD: begin
                        if (!level[i]) begin
                            state[i]  <= IDLE;
                            flag_q[i] <= 1'b1;
                        end else if (hold_cnt[i] == HOLD_LAST) begin
                            state[i] <= LONG;
                        end else begin
                            hold_cnt[i] <= hold_cnt[i] + 1'b1;
                        end
                    end
                    LONG: begin
                        // Hold counter stays frozen; release is silent.
                        if (!level[i]) begin
                            state[i] <= IDLE;
                        end
                    end
                    default: begin
                        state[i] <= IDLE;
                    end
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.flag_inputs = {{(8 - NUM_BTN){1'b0}}, flag_q};
    assign bus.long_press  = long_q;
    assign bus.reg_din     = sw_sync;
    assign bus.btn_level   = level;

endmodule
